conv_window_gen: RTL and testbench

- Streaming 3x3 window generator that sits directly upstream of the grayscale convolution filter stage.
- Accepts one raster-order 8-bit grayscale pixel per cycle and buffers two previous image rows internally.
- For every accepted pixel completing a full 3x3 neighbourhood ("valid" convolution, no padding), emits that window plus a one-cycle valid strobe. These drive the filter's pixel_i / data_valid.
- Produces (IMG_W-2)*(IMG_H-2) windows per frame.

---
 rtl/cnn_pkg.sv | 6 +
 rtl/conv_line_buffer.sv | 17 +
 rtl/conv_window_gen.sv | 67 ++++++
 tb/tb_conv_window_gen.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: pixel and 3x3 window types shared by the window generator and the filter stage
package cnn_pkg;
  localparam int PIX_W = 8;
  typedef logic [PIX_W-1:0] pixel_t;
  typedef pixel_t [2:0][2:0] window_t;
endpackage

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: one-row delay line, combinational read before the clocked write at the same index
module conv_line_buffer #(
  parameter int DEPTH = 28,
  parameter int PIX_W = cnn_pkg::PIX_W,
  parameter int IW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IW-1:0]    idx,
  input  logic [PIX_W-1:0] d,
  output logic [PIX_W-1:0] q
);
  logic [PIX_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[idx] <= d;
  assign q = mem[idx];
endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: raster pixel stream to 3x3 valid-convolution windows using two row buffers
module conv_window_gen #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int PIX_W = cnn_pkg::PIX_W
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         sof_i,
  input  logic [PIX_W-1:0]             pixel_i,
  input  logic                         pixel_valid_i,
  output logic [2:0][2:0][PIX_W-1:0]   window_o,
  output logic                         window_valid_o,
  output logic                         frame_done_o
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  logic [CW-1:0] col_q, col_eff, col_nxt;
  logic [RW-1:0] row_q, row_eff, row_nxt;
  logic [PIX_W-1:0] lb0_q, lb1_q;
  logic [2:0][2:0][PIX_W-1:0] win_q, win_nxt;
  logic last_col, last_row, emit, done;
  // sof_i relocates the accepted pixel to (0,0), abandoning any partial frame
  always_comb begin
    col_eff = sof_i ? '0 : col_q;
    row_eff = sof_i ? '0 : row_q;
    last_col = col_eff == COL_LAST;
    last_row = row_eff == ROW_LAST;
    col_nxt = last_col ? '0 : col_eff + 1'b1;
    row_nxt = !last_col ? row_eff : last_row ? '0 : row_eff + 1'b1;
    emit = pixel_valid_i && row_eff >= RW'(2) && col_eff >= CW'(2);
    done = pixel_valid_i && last_col && last_row;
    win_nxt = win_q;
    win_nxt[0][1:0] = win_q[0][2:1];
    win_nxt[1][1:0] = win_q[1][2:1];
    win_nxt[2][1:0] = win_q[2][2:1];
    win_nxt[0][2] = lb1_q;
    win_nxt[1][2] = lb0_q;
    win_nxt[2][2] = pixel_i;
  end
  conv_line_buffer #(.DEPTH(IMG_W), .PIX_W(PIX_W), .IW(CW)) u_lb0 (
    .clk(clk_i), .we(pixel_valid_i), .idx(col_eff), .d(pixel_i), .q(lb0_q)
  );
  conv_line_buffer #(.DEPTH(IMG_W), .PIX_W(PIX_W), .IW(CW)) u_lb1 (
    .clk(clk_i), .we(pixel_valid_i), .idx(col_eff), .d(lb0_q), .q(lb1_q)
  );
  always_ff @(posedge clk_i)
    if (pixel_valid_i) win_q <= win_nxt;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      col_q <= '0;
      row_q <= '0;
      window_o <= '0;
      window_valid_o <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      window_valid_o <= emit;
      frame_done_o <= done;
      if (pixel_valid_i) begin
        col_q <= col_nxt;
        row_q <= row_nxt;
      end
      if (emit) window_o <= win_nxt;
    end
endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: directed and random streams against a coordinate-based window scoreboard
module tb_conv_window_gen;
  typedef logic [2:0][2:0][7:0] win_t;
  logic clk = 1'b0;
  logic rst, sof, pv;
  logic [7:0] pix;
  win_t w4, w28;
  logic wv4, wv28, wd4, wd28;
  win_t exp_q[$];
  int n_assert = 0, n_fail = 0;
  bit big;
  int img_w, img_h, mcol, mrow, n_win, n_done;
  logic [7:0] img [28][28];
  win_t first_win;
  bit got_first;

  always #5 clk = ~clk;

  conv_window_gen #(.IMG_W(4), .IMG_H(4), .PIX_W(8)) u_d4 (
    .clk_i(clk), .rst_i(rst), .sof_i(sof), .pixel_i(pix), .pixel_valid_i(pv),
    .window_o(w4), .window_valid_o(wv4), .frame_done_o(wd4)
  );
  conv_window_gen #(.IMG_W(28), .IMG_H(28), .PIX_W(8)) u_d28 (
    .clk_i(clk), .rst_i(rst), .sof_i(sof), .pixel_i(pix), .pixel_valid_i(pv),
    .window_o(w28), .window_valid_o(wv28), .frame_done_o(wd28)
  );

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit v, input bit s, input logic [7:0] p);
    win_t e, wo;
    logic wv, wd;
    bit exp_v, exp_d;
    pv = v; sof = s; pix = p;
    @(posedge clk);
    exp_v = 0; exp_d = 0;
    if (v) begin
      if (s) begin mrow = 0; mcol = 0; end
      img[mrow][mcol] = p;
      if (mrow >= 2 && mcol >= 2) begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            e[r][c] = img[mrow-2+r][mcol-2+c];
        exp_q.push_back(e);
        exp_v = 1;
      end
      exp_d = (mrow == img_h-1 && mcol == img_w-1);
      if (mcol == img_w-1) begin
        mcol = 0;
        mrow = (mrow == img_h-1) ? 0 : mrow + 1;
      end else mcol++;
    end
    @(negedge clk);
    wv = big ? wv28 : wv4;
    wd = big ? wd28 : wd4;
    wo = big ? w28 : w4;
    chk("window_valid", wv, exp_v);
    if (wv && exp_q.size() > 0) begin
      n_win++;
      chk("window", wo, exp_q.pop_front());
      if (!got_first) begin first_win = wo; got_first = 1; end
    end
    chk("frame_done", wd, exp_d);
    if (wd) n_done++;
    pv = 0; sof = 0;
  endtask

  task automatic begin_test();
    n_win = 0; n_done = 0; got_first = 0;
  endtask

  task automatic end_test(input string tag, input int wins, input int dones);
    chk({tag, "_windows"}, n_win, wins);
    chk({tag, "_done_count"}, n_done, dones);
    chk({tag, "_queue_left"}, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1; pv = 0; sof = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    mrow = 0; mcol = 0;
    exp_q.delete();
  endtask

  initial begin
    rst = 1; pv = 0; sof = 0; pix = 0;
    big = 0; img_w = 4; img_h = 4; mrow = 0; mcol = 0;
    repeat (2) @(negedge clk);
    chk("rst_window", w4, 0);
    chk("rst_valid", wv4, 0);
    chk("rst_done", wd4, 0);
    rst = 0;

    begin_test();
    for (int i = 0; i < 16; i++) step(1, i == 0, 8'(i));
    end_test("ramp", 4, 1);
    chk("ramp_first", first_win, {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0});

    begin_test();
    for (int i = 0; i < 16; i++) begin
      step(1, i == 0, 8'(i));
      step(0, 0, 8'hff);
    end
    end_test("gaps", 4, 1);
    chk("gaps_first", first_win, {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0});

    begin_test();
    for (int i = 0; i < 16; i++) step(1, i == 0, 8'(i));
    end_test("b2b_f1", 4, 1);
    begin_test();
    for (int i = 0; i < 16; i++) step(1, 0, 8'(100 + i));
    end_test("b2b_f2", 4, 1);
    chk("b2b_first", first_win, {8'd110, 8'd109, 8'd108, 8'd106, 8'd105, 8'd104, 8'd102, 8'd101, 8'd100});

    begin_test();
    for (int i = 0; i < 6; i++) step(1, i == 0, 8'(50 + i));
    for (int i = 0; i < 16; i++) step(1, i == 0, 8'(i));
    end_test("abort", 4, 1);

    begin_test();
    for (int i = 0; i < 10; i++) step(1, i == 0, 8'(200 + i));
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("async_rst_window", w4, 0);
    chk("async_rst_valid", wv4, 0);
    chk("async_rst_done", wd4, 0);
    @(negedge clk);
    rst = 0;
    mrow = 0; mcol = 0;
    exp_q.delete();
    for (int i = 0; i < 16; i++) step(1, 0, 8'(i));
    end_test("after_rst", 4, 1);
    chk("after_rst_first", first_win, {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0});

    big = 1; img_w = 28; img_h = 28;
    do_reset();
    begin_test();
    for (int i = 0; i < 784; i++) step(1, i == 0, 8'($urandom_range(0, 255)));
    step(0, 0, 8'h00);
    end_test("random28", 676, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
